cache_dfp_arbiter: RTL

//   Shares the single 256-bit memory-side (DFP) port between the instruction cache and the data cache.
//   - Accepts line-granular read/write requests from both caches.
//   - Grants one requester at a time, round-robin on contention.
//   - Latches the granted request and holds it stable on the memory port until mem_resp.
//   - Returns the response only to the owner.
//   - Sits between the two cache stage-2 miss/writeback paths and the memory model / burst adapter.
//

---
 rtl/cache_dfp_arbiter_pkg.sv | 36 +++
 rtl/cache_dfp_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cache_dfp_arbiter_pkg.sv
// Shared types for the cache-to-memory (DFP) arbiter.
// Covers arbiter state, port owner and the latched line request.
package cache_dfp_arbiter_pkg;

    localparam int DFP_ADDR_W = 32;
    localparam int DFP_LINE_W = 256;
    localparam int OFFSET_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } dfp_op_t;

    typedef struct packed {
        logic [DFP_ADDR_W-1:0] addr;
        dfp_op_t               op;
        logic [DFP_LINE_W-1:0] wdata;
    } dfp_req_t;

    // A request with both strobes high is treated as a write.
    function automatic dfp_op_t op_of(input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/cache_dfp_arbiter.sv
// Round-robin arbiter sharing one 256-bit memory port between icache and dcache.
// Holds the granted request stable on the memory port until mem_resp.
module cache_dfp_arbiter
    import cache_dfp_arbiter_pkg::*;
#(
    parameter int ADDR_W = DFP_ADDR_W,
    parameter int LINE_W = DFP_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t last_grant_q, last_grant_d;
    dfp_req_t   txn_q, txn_d;

    logic       i_req;
    logic       d_req;
    logic       grant_valid;
    arb_owner_t grant_who;

    // last_grant starts at D so the very first tie goes to the icache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            txn_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            txn_q        <= txn_d;
        end
    end

    always_comb begin
        i_req        = i_read | i_write;
        d_req        = d_read | d_write;
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        txn_d        = txn_q;
        grant_valid  = 1'b0;
        grant_who    = OWN_I;
        i_rdata      = '0;
        i_resp       = 1'b0;
        d_rdata      = '0;
        d_resp       = 1'b0;
        mem_addr     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant_valid = 1'b1;
                    grant_who   = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
                end else if (i_req) begin
                    grant_valid = 1'b1;
                    grant_who   = OWN_I;
                end else if (d_req) begin
                    grant_valid = 1'b1;
                    grant_who   = OWN_D;
                end
            end
            BUSY: begin
                mem_addr  = txn_q.addr;
                mem_wdata = txn_q.wdata;
                mem_read  = (txn_q.op == OP_READ);
                mem_write = (txn_q.op == OP_WRITE);
                if (mem_resp) begin
                    state_d = DONE;
                    if (owner_q == OWN_I) begin
                        i_resp = 1'b1;
                        if (txn_q.op == OP_READ) i_rdata = mem_rdata;
                    end else begin
                        d_resp = 1'b1;
                        if (txn_q.op == OP_READ) d_rdata = mem_rdata;
                    end
                end
            end
            DONE: begin
                // The owner's request is still up from the finished transaction; only the other side may win here.
                if (owner_q == OWN_I && d_req) begin
                    grant_valid = 1'b1;
                    grant_who   = OWN_D;
                end else if (owner_q == OWN_D && i_req) begin
                    grant_valid = 1'b1;
                    grant_who   = OWN_I;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_valid) begin
            state_d      = BUSY;
            owner_d      = grant_who;
            last_grant_d = grant_who;
            if (grant_who == OWN_I) begin
                txn_d.addr  = i_addr & LINE_MASK;
                txn_d.op    = op_of(i_write);
                txn_d.wdata = i_wdata;
            end else begin
                txn_d.addr  = d_addr & LINE_MASK;
                txn_d.op    = op_of(d_write);
                txn_d.wdata = d_wdata;
            end
        end
    end

endmodule
